i3c_arbiter: RTL and testbench
==============================

I3C_ARBITER -- requirements
Module: i3c_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter IDLE_WORD, default 16'h0000, word shifted out in frames that no requester owns.
REQ-003 Parameter FRAME_LEN, default 18, bus_clk cycles per shifter frame (1 load + 16 shift + 1 done).
REQ-004 Parameter PICK_CYC, default 8, frame-cycle index at which the next owner is selected.
REQ-005 bus_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 req  in  NREQ  per-requester transfer request; held high until tx_ack.
REQ-008 tx_data  in  16*NREQ  packed transmit words; requester i occupies bits [16i+15:16i].
REQ-009 tx_ack  out  NREQ  one-cycle one-hot pulse: the word from requester i has been latched.
REQ-010 rx_data  out  16  received word, shared by all requesters.
REQ-011 rx_valid  out  NREQ  one-cycle one-hot pulse: rx_data belongs to requester i.
REQ-012 phy_din  out  16  word driven to the shifter's parallel input.
REQ-013 phy_dout  in  16  shifter's parallel output.
REQ-014 phy_ready  in  1  shifter's one-cycle frame-done pulse.
REQ-015 owner  out  3  current frame owner index; valid only when owner_vld=1.
REQ-016 owner_vld  out  1  current frame is owned by a requester.
REQ-017 sync_err  out  1  sticky flag: a frame lost alignment.

Function
REQ-018 States: SYNC (frame boundary not yet known) and RUN (aligned).
REQ-019 Frame counter fcnt, 5 bits: cleared to 0 in any cycle with phy_ready=1, otherwise incremented with saturation at 31.
REQ-020 SYNC: phy_din=IDLE_WORD, no tx_ack, no rx_valid, owner_vld=0; the first phy_ready moves to RUN with fcnt=0 and no owner for the current frame.
REQ-021 RUN, pick cycle fcnt==PICK_CYC: round-robin search over req, starting at the index after the last granted one (index 0 after reset); the winner's tx_data is registered into phy_din, the winner's tx_ack pulses in that same cycle, and the winner is stored as the next owner.
REQ-022 Pick cycle with req all zero: phy_din=IDLE_WORD, no next owner, round-robin pointer unchanged.
REQ-023 phy_din stays stable from the pick cycle until the next pick cycle, so it is stable across the shifter's load cycle.
REQ-024 RUN, phy_ready=1 with a current owner: rx_data<=phy_dout and rx_valid[owner] pulses one cycle later. Without a current owner, phy_dout is discarded.
REQ-025 On phy_ready the next owner becomes the current owner (owner, owner_vld); a request made after PICK_CYC waits for the next frame.
REQ-026 Latency: a req asserted at least 1 cycle before pick and won → tx_ack at pick; its rx_valid comes on the second phy_ready after that pick.
REQ-027 RUN, fcnt reaching FRAME_LEN+2 without phy_ready: set sync_err, go to SYNC, drop current and next owners (no rx_valid for them), phy_din=IDLE_WORD.
REQ-028 phy_ready while fcnt<PICK_CYC in RUN (short frame): set sync_err, treat it as a boundary with no next owner, and stay in RUN.
REQ-029 Simultaneous phy_ready and pick condition cannot occur for legal parameters (PICK_CYC>0); phy_ready takes precedence.
REQ-030 A requester that deasserts req before tx_ack is simply not considered; at most one tx_ack and one rx_valid bit is high in any cycle.

Reset
REQ-031 rst_n low: immediately state=SYNC, fcnt=0, phy_din=IDLE_WORD, tx_ack=0, rx_valid=0, rx_data=0, owner=0, owner_vld=0, sync_err=0, rr pointer=0.
REQ-032 Reset mid-frame discards all in-flight ownership; after release no rx_valid is produced until a new frame has been granted and completed.

Verification
REQ-033 Free-running shifter model, req=4'b0001, tx_data[15:0]=16'hA5C3, loopback phy_dout=phy_din of previous frame → tx_ack[0] at fcnt=8, rx_valid[0] with rx_data=16'hA5C3 two boundaries later.
REQ-034 req=4'b1111 held → grants rotate 0,1,2,3,0 on consecutive frames, one tx_ack per frame.
REQ-035 req=0 for 3 frames → phy_din=16'h0000 and no rx_valid; a req[2] raised at fcnt=9 → tx_ack[2] in the following frame only.
REQ-036 phy_ready withheld for 20 cycles in RUN → sync_err=1, state SYNC, pending owner dropped; next phy_ready resumes RUN.
REQ-037 rst_n pulsed low at fcnt=12 with owner 1 → all outputs at reset values asynchronously, rx_valid[1] never pulses.

Source files
------------

// File: rtl/i3c_arbiter.sv
// Round-robin arbiter that shares one 16-bit frame shifter among NREQ requesters.
// Picks the next owner mid-frame, hands completed frames back to the owner, and detects lost frame alignment.
module i3c_arbiter #(
  parameter int          NREQ      = 4,
  parameter logic [15:0] IDLE_WORD = 16'h0000,
  parameter int          FRAME_LEN = 18,
  parameter int          PICK_CYC  = 8
) (
  input  logic                 bus_clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   tx_data,
  output logic [NREQ-1:0]      tx_ack,
  output logic [15:0]          rx_data,
  output logic [NREQ-1:0]      rx_valid,
  output logic [15:0]          phy_din,
  input  logic [15:0]          phy_dout,
  input  logic                 phy_ready,
  output logic [2:0]           owner,
  output logic                 owner_vld,
  output logic                 sync_err
);

  typedef enum logic {SYNC, RUN} state_t;

  localparam logic [4:0] PICK    = 5'(PICK_CYC);
  localparam logic [4:0] TIMEOUT = 5'(FRAME_LEN + 2);

  state_t state_q, state_d;

  logic [4:0]        fcnt;
  logic [2:0]        rr_ptr;
  logic [2:0]        nxt_owner;
  logic              nxt_vld;

  logic              boundary, short_frame, timeout, pick_en;
  logic [2*NREQ-1:0] req_rot;
  logic [3:0]        rr_sum;
  logic [3:0]        ptr_sum;
  logic [2:0]        win_idx;
  logic              win_found;
  logic [2:0]        ptr_next;
  logic [15:0]       win_word;
  logic [NREQ-1:0]   owner_onehot;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    boundary    = 1'b0;
    short_frame = 1'b0;
    timeout     = 1'b0;
    pick_en     = 1'b0;
    case (state_q)
      SYNC: if (phy_ready) state_d = RUN;
      RUN: begin
        if (phy_ready) begin
          boundary    = 1'b1;
          short_frame = (fcnt < PICK);
        end else if (fcnt >= TIMEOUT) begin
          timeout = 1'b1;
          state_d = SYNC;
        end else if (fcnt == PICK) begin
          pick_en = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Rotate requests so bit 0 is the requester right after the last grant.
  always_comb begin
    req_rot   = {req, req} >> rr_ptr;
    rr_sum    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!win_found && req_rot[off]) begin
        win_found = 1'b1;
        rr_sum    = {1'b0, rr_ptr} + 4'(off);
        if (rr_sum >= 4'(NREQ)) rr_sum = rr_sum - 4'(NREQ);
        win_idx = rr_sum[2:0];
      end
    end
  end

  always_comb begin
    ptr_sum = {1'b0, win_idx} + 4'd1;
    if (ptr_sum >= 4'(NREQ)) ptr_sum = '0;
    ptr_next = ptr_sum[2:0];
  end

  always_comb begin
    win_word     = IDLE_WORD;
    tx_ack       = '0;
    owner_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == 3'(i)) win_word = tx_data[16*i +: 16];
      tx_ack[i]       = pick_en && win_found && (win_idx == 3'(i));
      owner_onehot[i] = (owner == 3'(i));
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      fcnt      <= '0;
      phy_din   <= IDLE_WORD;
      rx_data   <= '0;
      rx_valid  <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      nxt_owner <= '0;
      nxt_vld   <= 1'b0;
      rr_ptr    <= '0;
      sync_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_valid <= '0;

      if (phy_ready)             fcnt <= '0;
      else if (fcnt != 5'd31)    fcnt <= fcnt + 5'd1;

      if (boundary) begin
        if (owner_vld) begin
          rx_data  <= phy_dout;
          rx_valid <= owner_onehot;
        end
        owner     <= nxt_owner;
        owner_vld <= nxt_vld && !short_frame;
        nxt_vld   <= 1'b0;
        if (short_frame) sync_err <= 1'b1;
      end else if (timeout) begin
        // Alignment lost: whatever was in flight can no longer be attributed.
        sync_err  <= 1'b1;
        owner_vld <= 1'b0;
        nxt_vld   <= 1'b0;
        phy_din   <= IDLE_WORD;
      end else if (pick_en) begin
        if (win_found) begin
          phy_din   <= win_word;
          nxt_owner <= win_idx;
          nxt_vld   <= 1'b1;
          rr_ptr    <= ptr_next;
        end else begin
          phy_din   <= IDLE_WORD;
          nxt_vld   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i3c_arbiter.sv
// Directed bench for i3c_arbiter: a loopback frame shifter model plus hand-computed grant/receive expectations.
module tb_i3c_arbiter;

  logic        bus_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] tx_data;
  logic [3:0]  tx_ack;
  logic [15:0] rx_data;
  logic [3:0]  rx_valid;
  logic [15:0] phy_din;
  logic [15:0] phy_dout;
  logic        phy_ready;
  logic [2:0]  owner;
  logic        owner_vld;
  logic        sync_err;

  i3c_arbiter #(.NREQ(4), .IDLE_WORD(16'h0000), .FRAME_LEN(18), .PICK_CYC(8)) dut (
    .bus_clk   (bus_clk),
    .rst_n     (rst_n),
    .req       (req),
    .tx_data   (tx_data),
    .tx_ack    (tx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .phy_din   (phy_din),
    .phy_dout  (phy_dout),
    .phy_ready (phy_ready),
    .owner     (owner),
    .owner_vld (owner_vld),
    .sync_err  (sync_err)
  );

  always #5 bus_clk = ~bus_clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          sh_cnt;
  logic        sh_en;
  logic [15:0] sh_word;
  int          n_ack, n_rxv, n_multi;
  int          exp_g [5] = '{1, 2, 3, 0, 1};
  logic [3:0]  oh;

  function automatic logic [15:0] word(input int i);
    case (i)
      0:       return 16'hA5C3;
      1:       return 16'h1111;
      2:       return 16'h2222;
      default: return 16'h3333;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One bus_clk cycle: advance the 18-cycle shifter (load at 0, done at 17) and watch the pulses.
  task automatic step();
    @(posedge bus_clk);
    #1;
    if (sh_en) begin
      sh_cnt = (sh_cnt == 17) ? 0 : sh_cnt + 1;
      if (sh_cnt == 0) sh_word = phy_din;
      phy_ready = (sh_cnt == 17);
      phy_dout  = sh_word;
    end else begin
      phy_ready = 1'b0;
    end
    if (tx_ack !== 4'b0000)   n_ack++;
    if (rx_valid !== 4'b0000) n_rxv++;
    if ($countones(tx_ack) > 1 || $countones(rx_valid) > 1) n_multi++;
  endtask

  task automatic goto(input int n);
    int k;
    k = 0;
    step();
    while (sh_cnt != n && k < 40) begin
      step();
      k++;
    end
    if (sh_cnt != n) begin
      n_checks++;
      $error("FAIL goto: shifter count %0d never reached %0d", sh_cnt, n);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    tx_data   = {16'h3333, 16'h2222, 16'h1111, 16'hA5C3};
    phy_ready = 1'b0;
    phy_dout  = 16'h0000;
    sh_en     = 1'b1;
    sh_cnt    = 5;
    sh_word   = 16'h0000;
    n_ack = 0; n_rxv = 0; n_multi = 0;

    // Reset state
    repeat (3) step();
    check("rst_phy_din",   phy_din,   16'h0000);
    check("rst_tx_ack",    tx_ack,    4'b0000);
    check("rst_rx_valid",  rx_valid,  4'b0000);
    check("rst_rx_data",   rx_data,   16'h0000);
    check("rst_owner",     owner,     3'd0);
    check("rst_owner_vld", owner_vld, 1'b0);
    check("rst_sync_err",  sync_err,  1'b0);

    // SYNC: request present but nothing granted before the first boundary
    rst_n = 1'b1;
    req   = 4'b0001;
    n_ack = 0;
    goto(0);
    check("sync_no_ack", n_ack, 0);

    // Single requester loopback
    goto(8);
    check("lb_ack", tx_ack, 4'b0001);
    step();
    req = 4'b0000;
    check("lb_phy_din",   phy_din,   16'hA5C3);
    check("lb_no_owner",  owner_vld, 1'b0);
    goto(0);
    check("lb_owner_vld", owner_vld, 1'b1);
    check("lb_owner",     owner,     3'd0);
    check("lb_no_rx_yet", rx_valid,  4'b0000);
    goto(9);
    check("lb_idle_din",  phy_din,   16'h0000);
    goto(0);
    check("lb_rx_valid",  rx_valid,  4'b0001);
    check("lb_rx_data",   rx_data,   16'hA5C3);
    step();
    check("lb_rx_pulse",  rx_valid,  4'b0000);

    // All requesting: grants rotate from the requester after the last grant
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        goto(0);
        if (k >= 2) begin
          oh = 4'b0001 << exp_g[k-2];
          check("rr_rx_valid", rx_valid, oh);
          check("rr_rx_data",  rx_data,  word(exp_g[k-2]));
        end
      end
      goto(8);
      oh = 4'b0001 << exp_g[k];
      check("rr_ack", tx_ack, oh);
    end
    step();
    req = 4'b0000;
    goto(0);
    check("rr_rx_valid3", rx_valid, 4'b0001);
    check("rr_rx_data3",  rx_data,  16'hA5C3);
    goto(9);
    check("idle_din",     phy_din,  16'h0000);
    goto(0);
    check("rr_rx_valid4", rx_valid, 4'b0010);
    check("rr_rx_data4",  rx_data,  16'h1111);

    // Idle frames: nothing granted, nothing received
    n_ack = 0; n_rxv = 0;
    repeat (36) step();
    check("idle_no_rx",  n_rxv,   0);
    check("idle_no_ack", n_ack,   0);
    check("idle_din2",   phy_din, 16'h0000);

    // Late request (after pick) waits for the following frame
    goto(8);
    check("late_pre_ack", tx_ack, 4'b0000);
    goto(9);
    req = 4'b0100;
    check("late_no_ack", tx_ack, 4'b0000);
    goto(8);
    check("late_ack", tx_ack, 4'b0100);
    step();
    req = 4'b0000;
    goto(0);
    check("late_owner",     owner,     3'd2);
    check("late_owner_vld", owner_vld, 1'b1);
    check("late_no_rx",     rx_valid,  4'b0000);
    goto(0);
    check("late_rx_valid",  rx_valid,  4'b0100);
    check("late_rx_data",   rx_data,   16'h2222);

    // Withheld frame-done: timeout drops the pending owner
    step();
    req = 4'b0001;
    goto(8);
    check("to_ack", tx_ack, 4'b0001);
    step();
    req   = 4'b0000;
    sh_en = 1'b0;
    phy_ready = 1'b0;
    n_rxv = 0;
    repeat (20) step();
    check("to_sync_err",  sync_err,  1'b1);
    check("to_owner_vld", owner_vld, 1'b0);
    check("to_idle_din",  phy_din,   16'h0000);
    req    = 4'b0010;
    sh_cnt = 10;
    sh_en  = 1'b1;
    n_ack  = 0;
    goto(0);
    check("to_sync_no_ack", n_ack, 0);
    goto(8);
    check("resync_ack", tx_ack, 4'b0010);
    step();
    req = 4'b0000;
    goto(0);
    check("resync_owner",     owner,     3'd1);
    check("resync_owner_vld", owner_vld, 1'b1);
    check("to_dropped_no_rx", n_rxv,     0);

    // Asynchronous reset mid-frame while requester 1 owns the frame
    goto(12);
    rst_n = 1'b0;
    #1;
    check("ar_owner_vld", owner_vld, 1'b0);
    check("ar_owner",     owner,     3'd0);
    check("ar_sync_err",  sync_err,  1'b0);
    check("ar_phy_din",   phy_din,   16'h0000);
    check("ar_rx_data",   rx_data,   16'h0000);
    check("ar_rx_valid",  rx_valid,  4'b0000);
    n_rxv = 0;
    repeat (2) step();
    rst_n = 1'b1;
    goto(0);
    goto(3);
    check("ar_no_rx", n_rxv, 0);

    // Short frame: done pulse before pick sets sync_err, arbitration continues
    sh_cnt = 16;
    step();
    step();
    check("sf_sync_err", sync_err, 1'b1);
    req = 4'b1000;
    goto(8);
    check("sf_ack", tx_ack, 4'b1000);
    step();
    req = 4'b0000;
    check("onehot_pulses", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
